ping_reply_ctrl: RTL and testbench
==================================

# ping_reply_ctrl

Sequencer for the ICMP echo payload buffer. It takes the word stream for an echo request from the Ethernet RX parser, loads it into the payload buffer (start/write/end-of-packet strobes), and waits for the buffer's checksum to settle. It then requests the shared TX path from the TX arbiter and streams the buffered words out as the echo reply body. It also enforces the single-buffer occupancy rule and keeps received/dropped statistics.

## Interface
- MAX_WORDS, 255: largest accepted payload in 32-bit words; longer requests are dropped.
- GNT_TIMEOUT, 1024: cycles to wait for `i_tx_gnt` before abandoning a reply.
- SETTLE_CYC, 2: cycles between `o_pl_eop` rising and the first TX request; covers buffer checksum latch latency.

- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_rx_valid  in  1  RX word valid.
- i_rx_sop  in  1  first word of echo request; qualified by `i_rx_valid`.
- i_rx_eop  in  1  last word of request; qualified by `i_rx_valid`; may coincide with `i_rx_sop`.
- i_rx_err  in  1  CRC/length error flag; sampled with `i_rx_eop`.
- i_rx_data  in  32  RX word.
- o_pl_start  out  1  to buffer `i_start`; high with the first write.
- o_pl_wren  out  1  to buffer `i_wren`.
- o_pl_data  out  32  to buffer `i_in_data`; registered copy of `i_rx_data`.
- o_pl_eop  out  1  to buffer `i_eop`; level held from end of receive until reply done or abort.
- i_pl_data  in  32  buffer read data (word 0 carries checksum).
- o_pl_rdy  out  1  to buffer `i_out_rdy`; advance read pointer.
- o_tx_req  out  1  request to TX arbiter.
- i_tx_gnt  in  1  grant; must stay high until `o_tx_req` drops.
- o_tx_valid, o_tx_sop, o_tx_eop  out  1 each  TX word strobes.
- o_tx_data  out  32  TX word (= `i_pl_data`, combinational).
- i_tx_ready  in  1  TX sink accepts word when `o_tx_valid & i_tx_ready`.
- o_busy  out  1  high in any state other than IDLE.
- o_rx_cnt, o_drop_cnt  out  16 each  saturating counters of accepted and dropped requests.

## Operation
- States: IDLE, RECV, SETTLE, REQ, SEND, DROP.
- IDLE: on `i_rx_valid & i_rx_sop`, register word, assert `o_pl_start` + `o_pl_wren` next cycle, and set `wcnt` = 1.
  - If `i_rx_eop` is also high: go to SETTLE when `i_rx_err` = 0, otherwise go to DROP.
  - Otherwise go to RECV.
- RECV: each valid word is written (`o_pl_wren` one cycle later) and `wcnt` increments.
  - Valid `i_rx_sop` in RECV: restart; the new word is written with `o_pl_start`, `wcnt` = 1, and the partial packet counts as one drop.
  - On `i_rx_eop`: go to SETTLE; go to DROP instead if `i_rx_err` = 1.
  - If `wcnt` would exceed MAX_WORDS: stop writing and go to DROP at eop.
- SETTLE: `o_pl_eop` = 1; count SETTLE_CYC cycles, then go to REQ.
- REQ: `o_tx_req` = 1 while waiting for grant; timeout counter runs.
  - `i_tx_gnt` → SEND.
  - Counter reaches GNT_TIMEOUT → DROP.
- SEND: `o_tx_valid` = 1 with `o_tx_req` held.
  - `o_pl_rdy` = `o_tx_valid & i_tx_ready`; `scnt` counts transfers from 0.
  - `o_tx_sop` when `scnt` = 0; `o_tx_eop` when `scnt` = `wcnt`−1.
  - After the eop transfer: `o_rx_cnt`++, go to IDLE.
- DROP: `o_drop_cnt`++ (saturate at 0xFFFF), drop `o_pl_eop`, return to IDLE next cycle.
- RX words arriving outside IDLE/RECV are discarded. A valid sop arriving in SETTLE/REQ/SEND/DROP increments `o_drop_cnt` without disturbing the current reply.
- Buffer read pointer rewinds only on `o_pl_start`. The controller never pulses `o_pl_rdy` outside SEND, so SEND always starts at word 0.

## Timing
- Reset: all outputs 0, state IDLE, counters 0.
- Reset mid-operation returns to IDLE immediately; the buffer is reloaded by the next sop.
- RX→buffer write latency: 1 cycle.
- Last RX word → `o_tx_req` = 1: 1 + SETTLE_CYC cycles.
- `i_tx_gnt` high → `o_tx_valid` high: next cycle.
- `o_tx_req` drops the cycle after the eop transfer.
- One word per cycle when `i_tx_ready` is held high. With `i_tx_ready` low, `o_tx_data` and the strobes hold stable.
- `wcnt`/`scnt` are 9 bits; MAX_WORDS comparisons are unsigned.

## Test plan
- 4-word request, immediate grant, ready always 1: 4 writes with start on first; `o_tx_req` 3 cycles after last word; 4 TX words, sop on word 0 (the checksum), eop on word 3; `o_rx_cnt` = 1.
- Single-word request (sop+eop same cycle): one write, one TX word with sop and eop both high.
- Request with `i_rx_err` = 1 at eop: no `o_tx_req`; `o_drop_cnt` = 1; back to IDLE in ≤ 2 cycles.
- Grant withheld for GNT_TIMEOUT cycles: `o_tx_req` drops; `o_drop_cnt` +1; a following request is replied normally.
- `i_tx_ready` toggled 1/0 during a 10-word SEND: exactly 10 transfers; `o_pl_rdy` pulses only on accepted cycles; data in order.
- Second sop during SEND and 300-word request: the current reply completes intact, the second sop counts one drop, and the oversize request counts one drop with no TX.

Source files
------------

// File: rtl/ping_reply_ctrl.sv
// ping_reply_ctrl: loads an ICMP echo request into the payload buffer,
// waits for the buffer checksum to settle, wins the TX path and streams the
// buffered words back out as the echo reply body. Also keeps saturating
// received/dropped request counters.
module ping_reply_ctrl #(
  parameter int MAX_WORDS   = 255,
  parameter int GNT_TIMEOUT = 1024,
  parameter int SETTLE_CYC  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  // RX word stream from the Ethernet parser
  input  logic        i_rx_valid,
  input  logic        i_rx_sop,
  input  logic        i_rx_eop,
  input  logic        i_rx_err,
  input  logic [31:0] i_rx_data,
  // payload buffer write side
  output logic        o_pl_start,
  output logic        o_pl_wren,
  output logic [31:0] o_pl_data,
  output logic        o_pl_eop,
  // payload buffer read side
  input  logic [31:0] i_pl_data,
  output logic        o_pl_rdy,
  // TX arbiter / sink
  output logic        o_tx_req,
  input  logic        i_tx_gnt,
  output logic        o_tx_valid,
  output logic        o_tx_sop,
  output logic        o_tx_eop,
  output logic [31:0] o_tx_data,
  input  logic        i_tx_ready,
  // status
  output logic        o_busy,
  output logic [15:0] o_rx_cnt,
  output logic [15:0] o_drop_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RECV   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_REQ    = 3'd3;
  localparam logic [2:0] S_SEND   = 3'd4;
  localparam logic [2:0] S_DROP   = 3'd5;

  // word counters are 9 bits so a full MAX_WORDS payload plus overflow
  // detection fits without wrap
  localparam logic [8:0] MAX_W = 9'(MAX_WORDS);

  localparam int TW = $clog2(GNT_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(GNT_TIMEOUT - 1);

  // SETTLE lasts SETTLE_CYC cycles (minimum one)
  localparam int SW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  logic [2:0]    state, state_nx;
  logic [8:0]    wcnt, wcnt_nx;
  logic [8:0]    scnt;
  logic          ovf, ovf_nx;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] to_cnt;

  logic          wr_nx, start_nx;
  logic          rx_sop_v;
  logic          at_max;
  logic          xfer;
  logic          last_word;
  logic          rx_inc;
  logic [1:0]    drop_inc;
  logic [16:0]   drop_sum;

  assign rx_sop_v  = i_rx_valid & i_rx_sop;
  assign at_max    = (wcnt == MAX_W);
  assign xfer      = o_tx_valid & i_tx_ready;
  assign last_word = (scnt == wcnt - 9'd1);

  // state-decoded outputs; TX data is the buffer read port passed straight through
  assign o_busy     = (state != S_IDLE);
  assign o_pl_eop   = (state == S_SETTLE) | (state == S_REQ) | (state == S_SEND);
  assign o_tx_req   = (state == S_REQ) | (state == S_SEND);
  assign o_tx_valid = (state == S_SEND);
  assign o_tx_sop   = o_tx_valid & (scnt == 9'd0);
  assign o_tx_eop   = o_tx_valid & last_word;
  assign o_pl_rdy   = xfer;
  assign o_tx_data  = i_pl_data;

  // next-state, write strobes and counter increments
  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    ovf_nx   = ovf;
    wr_nx    = 1'b0;
    start_nx = 1'b0;
    rx_inc   = 1'b0;
    drop_inc = 2'd0;
    case (state)
      S_IDLE: begin
        if (rx_sop_v) begin
          wr_nx    = 1'b1;
          start_nx = 1'b1;
          wcnt_nx  = 9'd1;
          ovf_nx   = 1'b0;
          if (i_rx_eop) state_nx = i_rx_err ? S_DROP : S_SETTLE;
          else          state_nx = S_RECV;
        end
      end
      S_RECV: begin
        if (i_rx_valid) begin
          if (i_rx_sop) begin
            // restart: the abandoned partial packet is one drop
            drop_inc = 2'd1;
            wr_nx    = 1'b1;
            start_nx = 1'b1;
            wcnt_nx  = 9'd1;
            ovf_nx   = 1'b0;
            if (i_rx_eop) state_nx = i_rx_err ? S_DROP : S_SETTLE;
          end else begin
            // past MAX_WORDS stop writing but keep consuming to eop
            if (at_max) begin
              ovf_nx = 1'b1;
            end else begin
              wr_nx   = 1'b1;
              wcnt_nx = wcnt + 9'd1;
            end
            if (i_rx_eop)
              state_nx = (i_rx_err | ovf | at_max) ? S_DROP : S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (rx_sop_v) drop_inc = 2'd1;
        if (settle_cnt == SETTLE_LAST) state_nx = S_REQ;
      end
      S_REQ: begin
        if (rx_sop_v) drop_inc = 2'd1;
        if (i_tx_gnt)                state_nx = S_SEND;
        else if (to_cnt == TO_LAST)  state_nx = S_DROP;
      end
      S_SEND: begin
        if (rx_sop_v) drop_inc = 2'd1;
        if (xfer && last_word) begin
          rx_inc   = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_DROP: begin
        // the aborted packet plus any stray sop landing in the same cycle
        drop_inc = rx_sop_v ? 2'd2 : 2'd1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign drop_sum = {1'b0, o_drop_cnt} + {15'd0, drop_inc};

  // FSM state, packet length and registered buffer write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wcnt       <= 9'd0;
      ovf        <= 1'b0;
      o_pl_start <= 1'b0;
      o_pl_wren  <= 1'b0;
      o_pl_data  <= 32'd0;
    end else begin
      state      <= state_nx;
      wcnt       <= wcnt_nx;
      ovf        <= ovf_nx;
      o_pl_start <= start_nx;
      o_pl_wren  <= wr_nx;
      if (wr_nx) o_pl_data <= i_rx_data;
    end
  end

  // SETTLE and grant-timeout timers, cleared whenever their state is left
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      to_cnt     <= '0;
    end else begin
      settle_cnt <= (state == S_SETTLE) ? settle_cnt + 1'b1 : '0;
      to_cnt     <= (state == S_REQ)    ? to_cnt + 1'b1     : '0;
    end
  end

  // TX transfer index within the reply
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               scnt <= 9'd0;
    else if (state != S_SEND) scnt <= 9'd0;
    else if (xfer)            scnt <= scnt + 9'd1;
  end

  // saturating statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rx_cnt   <= 16'd0;
      o_drop_cnt <= 16'd0;
    end else begin
      if (rx_inc && o_rx_cnt != 16'hFFFF) o_rx_cnt <= o_rx_cnt + 16'd1;
      o_drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

endmodule

// File: tb/tb_ping_reply_ctrl.sv
// Bench for ping_reply_ctrl: behavioural payload buffer, scoreboard of
// expected TX words, table of request vectors plus hand-written corner cases.
module tb_ping_reply_ctrl;

  localparam int MAX_WORDS   = 255;
  localparam int GNT_TIMEOUT = 1024;
  localparam int SETTLE_CYC  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_rx_valid, i_rx_sop, i_rx_eop, i_rx_err;
  logic [31:0] i_rx_data;
  logic        o_pl_start, o_pl_wren, o_pl_eop, o_pl_rdy;
  logic [31:0] o_pl_data, i_pl_data;
  logic        o_tx_req, i_tx_gnt, o_tx_valid, o_tx_sop, o_tx_eop;
  logic [31:0] o_tx_data;
  logic        i_tx_ready;
  logic        o_busy;
  logic [15:0] o_rx_cnt, o_drop_cnt;

  ping_reply_ctrl #(
    .MAX_WORDS(MAX_WORDS), .GNT_TIMEOUT(GNT_TIMEOUT), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_rx_valid(i_rx_valid), .i_rx_sop(i_rx_sop), .i_rx_eop(i_rx_eop),
    .i_rx_err(i_rx_err), .i_rx_data(i_rx_data),
    .o_pl_start(o_pl_start), .o_pl_wren(o_pl_wren), .o_pl_data(o_pl_data),
    .o_pl_eop(o_pl_eop), .i_pl_data(i_pl_data), .o_pl_rdy(o_pl_rdy),
    .o_tx_req(o_tx_req), .i_tx_gnt(i_tx_gnt), .o_tx_valid(o_tx_valid),
    .o_tx_sop(o_tx_sop), .o_tx_eop(o_tx_eop), .o_tx_data(o_tx_data),
    .i_tx_ready(i_tx_ready), .o_busy(o_busy),
    .o_rx_cnt(o_rx_cnt), .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  // payload buffer model: start rewinds both pointers, rdy advances read
  logic [31:0] mem [0:511];
  logic [8:0]  wptr = 9'd0;
  logic [8:0]  rptr = 9'd0;
  logic [8:0]  waddr;
  assign waddr     = o_pl_start ? 9'd0 : wptr;
  assign i_pl_data = mem[rptr];
  always @(posedge clk) begin
    if (o_pl_wren) begin
      mem[waddr] <= o_pl_data;
      wptr       <= waddr + 9'd1;
    end
    if (o_pl_wren && o_pl_start) rptr <= 9'd0;
    else if (o_pl_rdy)           rptr <= rptr + 9'd1;
  end

  // arbiter grants immediately unless the test withholds it
  logic gnt_en = 1'b1;
  logic tog    = 1'b0;
  assign i_tx_gnt = gnt_en & o_tx_req;

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } exp_t;
  exp_t exp_q [$];

  typedef struct {
    int nwords;
    bit err;
    bit gnt;
    bit tog;
    bit reply;
    bit req;
    int exp_wr;
    int exp_drop;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int tx_count = 0, wr_count = 0, start_count = 0, start_bad = 0, rdy_bad = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard and protocol monitor, sampled on the falling edge
  task automatic monitor();
    exp_t e;
    logic pstall = 1'b0;
    logic [31:0] pdata = 32'd0;
    logic psop = 1'b0, peop = 1'b0;
    forever begin
      @(negedge clk);
      if (o_pl_wren) wr_count++;
      if (o_pl_wren && o_pl_start) start_count++;
      if (o_pl_start && !o_pl_wren) start_bad++;
      if (o_pl_rdy != (o_tx_valid && i_tx_ready)) rdy_bad++;
      if (pstall && o_tx_valid) begin
        chk("hold_data", o_tx_data, pdata);
        chk("hold_sop", o_tx_sop, psop);
        chk("hold_eop", o_tx_eop, peop);
      end
      if (o_tx_valid && i_tx_ready) begin
        tx_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got word %0h expected none", o_tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", o_tx_data, e.data);
          chk("sb_sop", o_tx_sop, e.sop);
          chk("sb_eop", o_tx_eop, e.eop);
        end
      end
      pstall = o_tx_valid && !i_tx_ready;
      pdata  = o_tx_data;
      psop   = o_tx_sop;
      peop   = o_tx_eop;
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #1;
      i_tx_ready = tog ? ~i_tx_ready : 1'b1;
    end
  endtask

  // drive n RX words back to back; expected TX words queued when push is set
  task automatic send_words(int n, bit err, bit eop, bit push);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      i_rx_valid = 1'b1;
      i_rx_sop   = (i == 0);
      i_rx_eop   = eop && (i == n - 1);
      i_rx_err   = err && (i == n - 1);
      i_rx_data  = $urandom;
      if (push) begin
        e.data = i_rx_data;
        e.sop  = (i == 0);
        e.eop  = (i == n - 1);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    i_rx_valid = 1'b0;
    i_rx_sop   = 1'b0;
    i_rx_eop   = 1'b0;
    i_rx_err   = 1'b0;
  endtask

  task automatic wait_idle(int budget, string name);
    int n = 0;
    while (o_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, o_busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  vec_t vec [9];

  initial begin
    int rx0, dr0, tx0, wr0, st0, lat, hi, n;

    // nwords, err, gnt, tog, reply, req, exp_wr, exp_drop
    vec[0] = '{4,   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4,   0};
    vec[1] = '{1,   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1,   0};
    vec[2] = '{5,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5,   1};
    vec[3] = '{3,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3,   1};
    vec[4] = '{2,   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2,   0};
    vec[5] = '{10,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 10,  0};
    vec[6] = '{255, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 255, 0};
    vec[7] = '{256, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 255, 1};
    vec[8] = '{300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 255, 1};

    rst_n = 1'b0;
    i_rx_valid = 1'b0; i_rx_sop = 1'b0; i_rx_eop = 1'b0; i_rx_err = 1'b0;
    i_rx_data = 32'd0;
    i_tx_ready = 1'b1;
    fork
      monitor();
      ready_drv();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_wr_strobes", {o_pl_start, o_pl_wren, o_pl_eop, o_pl_rdy}, 4'd0);
    chk("rst_tx_strobes", {o_tx_req, o_tx_valid, o_tx_sop, o_tx_eop}, 4'd0);
    chk("rst_pl_data", o_pl_data, 32'd0);
    chk("rst_rx_cnt", o_rx_cnt, 16'd0);
    chk("rst_drop_cnt", o_drop_cnt, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      rx0 = o_rx_cnt; dr0 = o_drop_cnt; tx0 = tx_count; wr0 = wr_count; st0 = start_count;
      gnt_en = vec[v].gnt;
      tog    = vec[v].tog;
      send_words(vec[v].nwords, vec[v].err, 1'b1, vec[v].reply);
      if (vec[v].req) begin
        lat = 0;
        do begin
          @(negedge clk);
          lat++;
        end while (!o_tx_req && lat < 10);
        chk($sformatf("v%0d_req_latency", v), lat, 1 + SETTLE_CYC);
        if (!vec[v].gnt) begin
          hi = 1;
          do begin
            @(negedge clk);
            if (o_tx_req) hi++;
          end while (o_tx_req && hi < GNT_TIMEOUT + 50);
          chk($sformatf("v%0d_timeout_len_%0d", v, hi),
              (hi >= GNT_TIMEOUT && hi <= GNT_TIMEOUT + 1), 1'b1);
        end
      end
      wait_idle(vec[v].reply ? 2 * vec[v].nwords + 20 : 2, $sformatf("v%0d_idle", v));
      chk($sformatf("v%0d_rx_inc", v), int'(o_rx_cnt) - rx0, vec[v].reply ? 1 : 0);
      chk($sformatf("v%0d_drop_inc", v), int'(o_drop_cnt) - dr0, vec[v].exp_drop);
      chk($sformatf("v%0d_tx_words", v), tx_count - tx0, vec[v].reply ? vec[v].nwords : 0);
      chk($sformatf("v%0d_writes", v), wr_count - wr0, vec[v].exp_wr);
      chk($sformatf("v%0d_starts", v), start_count - st0, 1);
    end
    gnt_en = 1'b1;

    // stray sop while a reply is being sent
    rx0 = o_rx_cnt; dr0 = o_drop_cnt; tx0 = tx_count; wr0 = wr_count;
    tog = 1'b1;
    send_words(6, 1'b0, 1'b1, 1'b1);
    n = 0;
    while (!o_tx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stray_send_seen", o_tx_valid, 1'b1);
    send_words(1, 1'b0, 1'b1, 1'b0);
    wait_idle(60, "stray_idle");
    chk("stray_drop_inc", int'(o_drop_cnt) - dr0, 1);
    chk("stray_rx_inc", int'(o_rx_cnt) - rx0, 1);
    chk("stray_tx_words", tx_count - tx0, 6);
    chk("stray_writes", wr_count - wr0, 6);
    tog = 1'b0;

    // sop mid-receive restarts the packet
    rx0 = o_rx_cnt; dr0 = o_drop_cnt; tx0 = tx_count; wr0 = wr_count; st0 = start_count;
    send_words(3, 1'b0, 1'b0, 1'b0);
    send_words(2, 1'b0, 1'b1, 1'b1);
    wait_idle(40, "restart_idle");
    chk("restart_drop_inc", int'(o_drop_cnt) - dr0, 1);
    chk("restart_rx_inc", int'(o_rx_cnt) - rx0, 1);
    chk("restart_tx_words", tx_count - tx0, 2);
    chk("restart_writes", wr_count - wr0, 5);
    chk("restart_starts", start_count - st0, 2);

    // reset in the middle of a receive
    send_words(3, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("midrst_busy", o_busy, 1'b0);
    chk("midrst_strobes", {o_pl_start, o_pl_wren, o_pl_eop, o_tx_req, o_tx_valid}, 5'd0);
    chk("midrst_counts", {o_rx_cnt, o_drop_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_words(2, 1'b0, 1'b1, 1'b1);
    wait_idle(40, "midrst_idle");
    chk("midrst_rx_cnt", o_rx_cnt, 16'd1);
    chk("midrst_drop_cnt", o_drop_cnt, 16'd0);

    repeat (2) @(negedge clk);
    chk("rdy_only_on_accept", rdy_bad, 0);
    chk("start_only_with_wren", start_bad, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
